// File: rtl/nes_pkg.sv
// Shared definitions for the CPU-side bus: memory map, RW encoding, loader state
// and the address-region decoder used by the bus responder.
package nes_pkg;

   localparam logic [15:0] RAM_BASE             = 16'h0000;
   localparam logic [15:0] RAM_LIMIT            = 16'h1FFF;
   localparam logic [15:0] PRG_BASE             = 16'h8000;
   localparam logic [15:0] ADDRESS_RESET_VECTOR = 16'hFFFC;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_RAM  = 2'd1,
      REG_PRG  = 2'd2
   } region_t;

   // Which source feeds o_data during the current CPU cycle.
   typedef enum logic [1:0] {
      SEL_OPEN = 2'd0,
      SEL_RAM  = 2'd1,
      SEL_PRG  = 2'd2
   } rd_sel_t;

   // RAM_BASE is zero, so only the upper bound needs testing for the RAM window.
   function automatic region_t decode_region(input logic [15:0] addr);
      region_t r;
      if (addr <= RAM_LIMIT)
         r = REG_RAM;
      else if (addr >= PRG_BASE)
         r = REG_PRG;
      else
         r = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/cpu_bus_memory_if.sv
// CPU bus and PRG loader handshake seen by the memory responder.
interface cpu_bus_memory_if;

   logic       i_rw;
   logic [15:0] i_address;
   logic [7:0] i_data;
   logic [7:0] o_data;

   logic       i_load_start;
   logic       i_load_valid;
   logic [7:0] i_load_data;
   logic       o_load_ready;
   logic       i_load_done;

   modport slave (
      input  i_rw, i_address, i_data,
      input  i_load_start, i_load_valid, i_load_data, i_load_done,
      output o_data, o_load_ready
   );

   modport master (
      output i_rw, i_address, i_data,
      output i_load_start, i_load_valid, i_load_data, i_load_done,
      input  o_data, o_load_ready
   );

endinterface

// File: rtl/cpu_bus_memory_sync_ram.sv
// Single-port byte-wide RAM with registered read; contents are never reset.
module sync_ram #(
   parameter int ADDR_BITS = 11,
   parameter int DATA_W    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   output logic [DATA_W-1:0]    o_rdata
);

   logic [DATA_W-1:0] mem [0:(2**ADDR_BITS)-1];

   // Read returns the pre-write contents when reading and writing the same word.
   always_ff @(posedge i_clk) begin
      if (i_we)
         mem[i_addr] <= i_wdata;
      o_rdata <= mem[i_addr];
   end

endmodule

// File: rtl/cpu_bus_memory.sv
// 6502 bus responder: mirrored work RAM, PRG ROM window, open-bus latch, and the
// PRG loader that holds the CPU in reset until the image has been streamed in.
module cpu_bus_memory
   import nes_pkg::*;
#(
   parameter int RAM_ADDR_BITS = 11,
   parameter int PRG_ADDR_BITS = 15
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   cpu_bus_memory_if.slave        bus,
   output logic                   o_cpu_reset_n,
   output logic [PRG_ADDR_BITS:0] o_load_count,
   output logic                   o_running
);

   localparam logic [PRG_ADDR_BITS:0] PRG_LAST = {1'b0, {PRG_ADDR_BITS{1'b1}}};

   state_t                   state;
   logic [PRG_ADDR_BITS:0]   count;
   rd_sel_t                  rd_sel;
   logic [7:0]               open_bus;
   logic [7:0]               ram_q;
   logic [7:0]               prg_q;
   logic [7:0]               data_out;

   region_t                  region;
   logic                     run;
   logic                     cpu_wr;
   logic                     cpu_rd;
   logic                     ram_we;
   logic                     load_xfer;
   logic                     last_byte;
   logic                     prg_we;
   logic [PRG_ADDR_BITS-1:0] prg_addr;

   assign region    = decode_region(bus.i_address);
   assign run       = (state == ST_RUN);
   assign cpu_wr    = run && (bus.i_rw == RW_WRITE);
   assign cpu_rd    = run && (bus.i_rw == RW_READ);
   assign ram_we    = cpu_wr && (region == REG_RAM);

   // A restart pulse takes priority over a byte offered in the same cycle.
   assign load_xfer = !run && bus.i_load_valid && !bus.i_load_start;
   assign last_byte = load_xfer && (count == PRG_LAST);

   // PRG is written only by the loader; the CPU sees it as ROM.
   assign prg_we   = load_xfer;
   assign prg_addr = run ? bus.i_address[PRG_ADDR_BITS-1:0] : count[PRG_ADDR_BITS-1:0];

   sync_ram #(.ADDR_BITS(RAM_ADDR_BITS), .DATA_W(8)) u_work_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_addr  (bus.i_address[RAM_ADDR_BITS-1:0]),
      .i_wdata (bus.i_data),
      .o_rdata (ram_q)
   );

   sync_ram #(.ADDR_BITS(PRG_ADDR_BITS), .DATA_W(8)) u_prg_rom (
      .i_clk   (i_clk),
      .i_we    (prg_we),
      .i_addr  (prg_addr),
      .i_wdata (bus.i_load_data),
      .o_rdata (prg_q)
   );

   // Loader / run control
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= ST_LOAD;
         count         <= '0;
         o_cpu_reset_n <= 1'b0;
      end else begin
         o_cpu_reset_n <= run;
         case (state)
            ST_LOAD: begin
               if (bus.i_load_start) begin
                  count <= '0;
               end else begin
                  if (load_xfer)
                     count <= count + 1'b1;
                  if (last_byte || bus.i_load_done)
                     state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.i_load_start) begin
                  state <= ST_LOAD;
                  count <= '0;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   // Read-source select and open-bus latch; CPU write data beats a prior read.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rd_sel   <= SEL_OPEN;
         open_bus <= 8'h00;
      end else begin
         if (cpu_wr)
            open_bus <= bus.i_data;
         else if (rd_sel != SEL_OPEN)
            open_bus <= data_out;

         if (cpu_rd) begin
            case (region)
               REG_RAM: rd_sel <= SEL_RAM;
               REG_PRG: rd_sel <= SEL_PRG;
               default: rd_sel <= SEL_OPEN;
            endcase
         end else begin
            rd_sel <= SEL_OPEN;
         end
      end
   end

   // Selection is registered, so o_data depends only on flops, never on the address.
   always_comb begin
      data_out = open_bus;
      case (rd_sel)
         SEL_RAM: data_out = ram_q;
         SEL_PRG: data_out = prg_q;
         default: data_out = open_bus;
      endcase
   end

   assign bus.o_data       = data_out;
   assign bus.o_load_ready = !run;
   assign o_load_count     = count;
   assign o_running        = run;

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Directed bench for cpu_bus_memory: PRG loading, reset vector fetch, RAM mirroring,
// open-bus behaviour and loader restart / reset corner cases.
module tb_cpu_bus_memory;
   import nes_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_reset_n;
   logic [15:0] load_count;
   logic        running;

   int errors = 0;
   int checks = 0;

   logic [7:0] prg_m [0:32767];
   logic [7:0] exp_q [$];
   string      tag_q [$];

   cpu_bus_memory_if bus ();

   cpu_bus_memory #(.RAM_ADDR_BITS(11), .PRG_ADDR_BITS(15)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .bus           (bus.slave),
      .o_cpu_reset_n (cpu_reset_n),
      .o_load_count  (load_count),
      .o_running     (running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
      logic [7:0] e;
      string      t;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      bus.i_rw      = RW_READ;
      bus.i_address = addr;
      tick();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {24'h0, bus.o_data}, {24'h0, e});
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d);
      bus.i_rw      = RW_WRITE;
      bus.i_address = addr;
      bus.i_data    = d;
      tick();
      bus.i_rw      = RW_READ;
      bus.i_address = 16'h5000;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [14:0] at);
      bus.i_load_valid = 1'b1;
      bus.i_load_data  = d;
      prg_m[at]        = d;
      tick();
      bus.i_load_valid = 1'b0;
   endtask

   task automatic pulse_done();
      bus.i_load_done = 1'b1;
      tick();
      bus.i_load_done = 1'b0;
   endtask

   task automatic pulse_start();
      bus.i_load_start = 1'b1;
      tick();
      bus.i_load_start = 1'b0;
   endtask

   initial begin
      logic [14:0] idx;
      rst              = 1'b1;
      bus.i_rw         = RW_READ;
      bus.i_address    = 16'h5000;
      bus.i_data       = 8'h00;
      bus.i_load_start = 1'b0;
      bus.i_load_valid = 1'b0;
      bus.i_load_data  = 8'h00;
      bus.i_load_done  = 1'b0;
      for (int i = 0; i < 32768; i++) begin
         idx      = 15'(i);
         prg_m[i] = idx[7:0] ^ idx[14:7];
      end
      prg_m[15'h7FFC] = 8'h00;
      prg_m[15'h7FFD] = 8'h80;

      repeat (3) tick();
      check("reset_running",   {31'h0, running},      32'h0);
      check("reset_cpu_rst_n", {31'h0, cpu_reset_n},  32'h0);
      check("reset_count",     {16'h0, load_count},   32'h0);
      check("reset_odata",     {24'h0, bus.o_data},   32'h0);
      check("reset_ready",     {31'h0, bus.o_load_ready}, 32'h1);
      rst = 1'b0;

      // Full image load, one byte per cycle
      bus.i_load_valid = 1'b1;
      for (int i = 0; i < 32768; i++) begin
         bus.i_load_data = prg_m[i];
         tick();
      end
      bus.i_load_valid = 1'b0;
      check("full_count",      {16'h0, load_count},   32'd32768);
      check("full_running",    {31'h0, running},      32'h1);
      check("full_ready",      {31'h0, bus.o_load_ready}, 32'h0);
      check("full_rstn_early", {31'h0, cpu_reset_n},  32'h0);
      tick();
      check("full_rstn_rise",  {31'h0, cpu_reset_n},  32'h1);
      cpu_read(ADDRESS_RESET_VECTOR,         8'h00, "vector_lo");
      cpu_read(ADDRESS_RESET_VECTOR + 16'd1, 8'h80, "vector_hi");

      // Short load ended early by done
      pulse_start();
      check("short_running0",  {31'h0, running},      32'h0);
      check("short_rstn_hold", {31'h0, cpu_reset_n},  32'h1);
      send_byte(8'hA9, 15'd0);
      check("short_rstn_fall", {31'h0, cpu_reset_n},  32'h0);
      send_byte(8'h01, 15'd1);
      send_byte(8'hEA, 15'd2);
      send_byte(8'hEA, 15'd3);
      pulse_done();
      check("short_count",     {16'h0, load_count},   32'd4);
      check("short_running1",  {31'h0, running},      32'h1);
      cpu_read(16'h8002, prg_m[2], "short_rd_8002");
      bus.i_load_valid = 1'b1;
      bus.i_load_data  = 8'h77;
      tick();
      bus.i_load_valid = 1'b0;
      check("run_valid_ignored", {16'h0, load_count}, 32'd4);
      cpu_read(16'h8004, prg_m[4], "run_byte_not_written");

      // RAM mirroring
      cpu_write(16'h0005, 8'h5A);
      cpu_read(16'h0805, 8'h5A, "mirror_0805");
      cpu_read(16'h1805, 8'h5A, "mirror_1805");

      // Open bus and ROM write protection
      cpu_read(16'h8000, 8'hA9, "rd_8000");
      cpu_read(16'h4016, 8'hA9, "openbus_read");
      cpu_write(16'hC000, 8'h33);
      cpu_read(16'h6000, 8'h33, "openbus_write");
      cpu_read(16'hC000, prg_m[15'h4000], "rom_write_ignored");

      // Restart together with a byte: restart wins, byte dropped
      pulse_start();
      send_byte(8'h11, 15'd0);
      check("restart_count1", {16'h0, load_count}, 32'd1);
      bus.i_load_start = 1'b1;
      bus.i_load_valid = 1'b1;
      bus.i_load_data  = 8'h22;
      tick();
      bus.i_load_start = 1'b0;
      bus.i_load_valid = 1'b0;
      check("restart_count0", {16'h0, load_count}, 32'd0);
      send_byte(8'h5C, 15'd0);
      check("restart_count_next", {16'h0, load_count}, 32'd1);
      pulse_done();
      cpu_read(16'h8000, 8'h5C, "restart_prg0");
      cpu_read(16'h8001, prg_m[1], "restart_drop");

      // Reset while running
      cpu_read(16'h8000, 8'h5C, "pre_reset_rd");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_run_running", {31'h0, running},     32'h0);
      check("rst_run_rstn",    {31'h0, cpu_reset_n}, 32'h0);
      check("rst_run_odata",   {24'h0, bus.o_data},  32'h0);
      check("rst_run_count",   {16'h0, load_count},  32'h0);
      pulse_done();
      cpu_read(16'h0005, 8'h5A, "ram_survives_reset");
      cpu_read(16'h8002, prg_m[2], "prg_survives_reset");

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_bus_memory.md
# cpu_bus_memory

Responder on the far end of the 6502 CPU bus: decodes the CPU's address/RW each cycle, serves 2 KB of mirrored work RAM and a PRG ROM window, and returns read data in time for the CPU's falling-edge sample. It also owns the PRG loader: it holds the CPU in reset while a host streams the program image in, then releases it so the CPU fetches its reset vector from `$FFFC`/`$FFFD`.

## Interface
- `RAM_ADDR_BITS`, 11: work RAM depth is 2^11 bytes, mirrored across `$0000`–`$1FFF`.
- `PRG_ADDR_BITS`, 15: PRG depth is 2^15 bytes, mapped at `$8000`–`$FFFF`, mirrored if smaller.
- `i_clk`  in  1  — single clock. One clock; reset is synchronous and active-high.
- `i_reset`  in  1  — synchronous, active-high.
- `i_rw`  in  1  — from CPU; 1 = read, 0 = write.
- `i_address`  in  16  — from CPU.
- `i_data`  in  8  — CPU write data.
- `o_data`  out  8  — read data to CPU.
- `o_cpu_reset_n`  out  1  — drives the CPU's `i_reset_n`.
- `i_load_start`  in  1  — pulse; restart loading.
- `i_load_valid`  in  1  — loader byte valid.
- `i_load_data`  in  8  — loader byte.
- `o_load_ready`  out  1  — loader may transfer.
- `i_load_done`  in  1  — pulse; end load early.
- `o_load_count`  out  PRG_ADDR_BITS+1  — bytes accepted in the current load.
- `o_running`  out  1  — state is RUN.

## Operation
- States: LOAD, RUN. Reset enters LOAD with count 0.
- LOAD:
  - `o_load_ready`=1.
  - On `i_load_valid`&&`o_load_ready`, write `i_load_data` to PRG[count] and increment count.
  - Exit to RUN when the 2^PRG_ADDR_BITS-th byte is accepted, or on `i_load_done`. If `i_load_done` coincides with a valid transfer, the byte is written first.
  - Bytes not loaded keep their previous contents.
- RUN:
  - `o_load_ready`=0 and load bytes are ignored.
  - `i_load_start` returns to LOAD with count 0.
- In LOAD, `i_load_start` resets count to 0. When `i_load_start` and a transfer happen in the same cycle, `i_load_start` wins and the byte is dropped.
- Address decode, RUN only:
  - `$0000`–`$1FFF`: RAM[addr[RAM_ADDR_BITS-1:0]], read/write.
  - `$8000`–`$FFFF`: PRG[addr[PRG_ADDR_BITS-1:0]], read only; writes are ignored.
  - `$2000`–`$7FFF`: unmapped. Reads return the open-bus latch; writes are ignored.
- Open-bus latch:
  - Updated with every byte the block drives on `o_data` from RAM/PRG.
  - Updated with every CPU write data byte.
- In LOAD, CPU writes are ignored and `o_data` holds its last value.
- RAM is not cleared by reset. The open-bus latch and `o_data` reset to `$00`.

## Timing
- All state changes happen on posedge `i_clk`. The CPU drives `i_address`/`i_rw` after its falling edge and samples `i_data` at the next falling edge.
- Read: `o_data` is registered at the posedge following the address change, so it is valid half a cycle before the CPU sample. Read latency is 1 posedge; no combinational path from address to `o_data`.
- Write: RAM is updated at the posedge while `i_rw`=0. A read of the same address in the next cycle returns the new value.
- `o_cpu_reset_n` is registered:
  - 0 from reset and throughout LOAD.
  - Rises at the posedge after RUN is entered.
  - Falls at the posedge after a return to LOAD.
- `o_running` follows the state register.
- Reset values:
  - state LOAD, count 0
  - `o_load_ready` 1 (combinational from state)
  - `o_cpu_reset_n` 0, `o_data` `$00`, `o_running` 0
- Reset mid-load discards the count. PRG bytes already written remain.

## Structure
- Shared package `nes_pkg`:
  - region base/limit constants (`RAM_BASE`, `RAM_LIMIT`, `PRG_BASE`)
  - `ADDRESS_RESET_VECTOR` = `$FFFC`
  - RW encodings `RW_READ`=1, `RW_WRITE`=0
  - state enum
- One sub-module, `sync_ram`: single-port, parameterised depth, registered read, write-enable. Instantiated twice (RAM, PRG). The PRG port is muxed between the loader (LOAD) and the CPU (RUN).

## Test plan
- Reset, then load 32768 bytes with PRG[$7FFC]=`$00`, PRG[$7FFD]=`$80`, then idle 2 cycles:
  - `o_load_count`=32768
  - `o_running`=1
  - `o_cpu_reset_n` rises one cycle after RUN
  - CPU read of `$FFFC` returns `$00`; `$FFFD` returns `$80`
- Load 4 bytes `$A9,$01,$EA,$EA`, then pulse `i_load_done`:
  - count=4, RUN
  - read `$8002` -> `$EA`
  - `i_load_valid` in RUN is ignored (count stays 4)
- RUN, write `$5A` to `$0005`, then read `$0805` and `$1805`:
  - both return `$5A` (mirror)
- RUN, read `$8000`=`$A9`, then read `$4016`:
  - `$4016` returns `$A9` (open bus)
  - write `$33` to `$C000`: a later read of `$C000` still returns its loaded value
  - a read of `$6000` then returns `$33`
- Mid-load `i_load_start` together with `i_load_valid`:
  - count goes to 0 and the byte is dropped
  - next byte lands at PRG[0]
- `i_reset` asserted in RUN:
  - next cycle: state LOAD, `o_cpu_reset_n`=0, `o_data`=`$00`
  - RAM contents survive
